// File: rtl/pdec_pkg.sv
// Shared definitions for the priority-decoder stream block: default index
// width and the frame-tracking state encoding.
package pdec_pkg;

  // Default index width; the decoded word and the mask are 2**W bits wide.
  localparam int DEF_W = 3;

  // Frame tracker: IDLE between frames, ACCUM inside a frame, DONE for the
  // single cycle after a frame's last index (drives mask_valid).
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/onehot_dec.sv
// Combinational W-to-2**W one-hot decoder. Every index value is legal.
module onehot_dec
  import pdec_pkg::*;
#(
  parameter  int W = DEF_W,
  localparam int N = 1 << W
) (
  input  logic [W-1:0] idx,
  output logic [N-1:0] onehot
);

  // Set the single bit selected by idx.
  always_comb begin
    // NOTE: assigning a default before the indexed write keeps every bit
    // driven on every path, so no latch is inferred.
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/pdecoder_stream.sv
// Receiving end of a priority-encoder link. Each accepted index is emitted
// as a registered one-hot word through a one-entry, bubble-free output
// buffer. Indices are OR-ed into an accumulator until the index tagged
// last, when the completed frame's mask is published with a one-cycle
// mask_valid pulse. A repeated index within a frame raises dup_err.
module pdecoder_stream
  import pdec_pkg::*;
#(
  parameter  int W = DEF_W,
  localparam int N = 1 << W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_idx,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [N-1:0] out_onehot,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] mask,
  output logic         mask_valid,
  output logic         dup_err
);

  logic [N-1:0] dec;
  logic [N-1:0] acc;
  logic         accept;
  logic         hit;
  state_t       state;
  state_t       state_nxt;

  onehot_dec #(.W(W)) u_dec (
    .idx    (in_idx),
    .onehot (dec)
  );

  // The buffer frees up in the same cycle its word is consumed, so a new
  // index can replace it without a bubble. Held low while in reset.
  assign in_ready = rst_n && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign hit      = |(acc & dec);

  // One-entry output buffer: load on accept, empty on consume-without-refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_onehot <= '0;
      out_valid  <= 1'b0;
    end else if (accept) begin
      // NOTE: registered state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      out_onehot <= dec;
      out_valid  <= 1'b1;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  // Frame accumulator, published mask and duplicate-index flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      mask    <= '0;
      dup_err <= 1'b0;
    end else begin
      dup_err <= accept && hit;
      if (accept && in_last) begin
        mask <= acc | dec;
        acc  <= '0;
      end else if (accept) begin
        acc  <= acc | dec;
      end
    end
  end

  // Frame-tracker state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Frame-tracker next state; a last index always lands in DONE so that
  // back-to-back frames keep mask_valid high.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) state_nxt = in_last ? DONE : ACCUM;
      end
      ACCUM: begin
        if (accept && in_last) state_nxt = DONE;
      end
      DONE: begin
        if (accept) state_nxt = in_last ? DONE : ACCUM;
        else        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mask_valid = (state == DONE);

endmodule
